// File: rtl/reversi_pkg.sv
// Shared types for the reversi board front end: move directions, board
// geometry, and the priority encoder used to pick one direction out of
// several simultaneous buttons (right > left > up > down).
package reversi_pkg;

  localparam int BOARD_DIM = 8;
  localparam int COORD_W   = 3;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_RIGHT,
    DIR_LEFT,
    DIR_UP,
    DIR_DOWN
  } dir_t;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rptState_t;

  // Button vector bit order: [0]=right [1]=left [2]=up [3]=down.
  function automatic dir_t prioDir(input logic [3:0] btnVec);
    if (btnVec[0]) return DIR_RIGHT;
    if (btnVec[1]) return DIR_LEFT;
    if (btnVec[2]) return DIR_UP;
    if (btnVec[3]) return DIR_DOWN;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: two-flop synchronizer followed by a debounce counter.
// The stable level flips only after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles. rise is a one-cycle
// pulse coincident with the first cycle stable reads 1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btnRaw,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic syncP0;
  logic syncP1;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncP0 <= 1'b0;
      syncP1 <= 1'b0;
    end else begin
      syncP0 <= btnRaw;
      syncP1 <= syncP0;
    end
  end

  // Count disagreement cycles; flip the stable level at the terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      rise <= 1'b0;
      if (syncP1 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= ~stable;
          rise   <= ~stable;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/move_cmd_gen.sv
// Turns four raw pushbuttons into one-cycle move commands with a one-hot
// direction, priority right > left > up > down. Simultaneous presses keep
// only the winner. Define REPEAT_EN to add keyboard-style auto-repeat on the
// highest-priority held button; without it only press events emit pulses.
module move_cmd_gen
  import reversi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 7500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_right,
  input  logic btn_left,
  input  logic btn_up,
  input  logic btn_down,
  output logic move_en,
  output logic move_right_en,
  output logic move_left_en,
  output logic move_up_en,
  output logic move_down_en
);

  // Zero-length timing parameters make no sense; this empty block just pins
  // that assumption next to the parameter list.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gBadCfg
  end

  logic [3:0] rawVec;
  logic [3:0] stableVec;
  logic [3:0] riseVec;
  logic [3:0] pressVec;
  dir_t       pressDir;
  dir_t       cmdDir;

  assign rawVec = {btn_down, btn_up, btn_left, btn_right};

  for (genvar i = 0; i < 4; i++) begin : gBtn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDeb (
      .clk   (clk),
      .reset (reset),
      .btnRaw(rawVec[i]),
      .stable(stableVec[i]),
      .rise  (riseVec[i])
    );
  end

  // A rise is only honoured while the button still reads as held.
  assign pressVec = riseVec & stableVec;
  assign pressDir = prioDir(pressVec);

`ifdef REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  rptState_t        rptState;
  dir_t             rptDir;
  logic [RPT_W-1:0] rptCnt;
  dir_t             heldTop;
  logic             rptFire;

  assign heldTop = prioDir(stableVec);

  // Auto-repeat timer tracking the highest-priority held button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptState <= RPT_IDLE;
      rptDir   <= DIR_NONE;
      rptCnt   <= '0;
    end else if (heldTop == DIR_NONE) begin
      rptState <= RPT_IDLE;
      rptDir   <= DIR_NONE;
      rptCnt   <= '0;
    end else if (heldTop != rptDir) begin
      // New top button: its press pulse comes from the press path.
      rptState <= RPT_DELAY;
      rptDir   <= heldTop;
      rptCnt   <= '0;
    end else begin
      case (rptState)
        RPT_DELAY: begin
          if (rptCnt == DELAY_LAST) begin
            rptState <= RPT_REPEAT;
            rptCnt   <= '0;
          end else begin
            rptCnt <= rptCnt + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (rptCnt == PERIOD_LAST) rptCnt <= '0;
          else                       rptCnt <= rptCnt + 1'b1;
        end
        default: rptCnt <= '0;
      endcase
    end
  end

  assign rptFire = (heldTop != DIR_NONE) && (heldTop == rptDir) &&
                   (((rptState == RPT_DELAY)  && (rptCnt == DELAY_LAST)) ||
                    ((rptState == RPT_REPEAT) && (rptCnt == PERIOD_LAST)));

  // Press pulses take precedence; a repeat slot that collides is skipped.
  assign cmdDir = (pressDir != DIR_NONE) ? pressDir :
                  (rptFire ? rptDir : DIR_NONE);
`else
  assign cmdDir = pressDir;
`endif

  // Registered command outputs: one-hot direction only alongside move_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_en       <= 1'b0;
      move_right_en <= 1'b0;
      move_left_en  <= 1'b0;
      move_up_en    <= 1'b0;
      move_down_en  <= 1'b0;
    end else begin
      move_en       <= (cmdDir != DIR_NONE);
      move_right_en <= (cmdDir == DIR_RIGHT);
      move_left_en  <= (cmdDir == DIR_LEFT);
      move_up_en    <= (cmdDir == DIR_UP);
      move_down_en  <= (cmdDir == DIR_DOWN);
    end
  end

endmodule

// File: tb/tb_move_cmd_gen.sv
// Randomized + directed bench for move_cmd_gen with a scoreboard. The
// reference model treats each button as "stable flips once the last D
// sampled raw values all disagree with it", then emits the highest-priority
// press one cycle later.
module tb_move_cmd_gen;

  localparam int D    = 4;
  localparam int RD   = 20;
  localparam int RP   = 5;
  localparam int HMAX = 8192;

  logic clk = 1'b0;
  logic reset;
  logic btn_right, btn_left, btn_up, btn_down;
  logic move_en, move_right_en, move_left_en, move_up_en, move_down_en;

  move_cmd_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_right    (btn_right),
    .btn_left     (btn_left),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .move_en      (move_en),
    .move_right_en(move_right_en),
    .move_left_en (move_left_en),
    .move_up_en   (move_up_en),
    .move_down_en (move_down_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
  } exp_t;

  exp_t       expQ[$];
  logic [3:0] hist[0:HMAX-1];
  int         cyc;
  int         nTests;
  int         nFail;

  // Direction index: 0 none, 1 right, 2 left, 3 up, 4 down.
  function automatic int prioOf(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  // {move_en, right, left, up, down}
  function automatic logic [4:0] vecOf(input int d);
    logic [3:0] oneHot;
    if (d == 0) return 5'b0;
    oneHot = 4'b1000 >> (d - 1);
    return {1'b1, oneHot};
  endfunction

  // Reference model, evaluated at every rising edge.
  initial begin
    logic [3:0] mStable, pending, press, raw;
    int  outDir, mTop, topSince, k;
    bit  allOpp;
    mStable = '0; pending = '0; mTop = 0; topSince = 0; k = 0;
    cyc = 0;
    for (int i = 0; i < HMAX; i++) hist[i] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc >= HMAX) begin
        $display("FAIL model_history cyc=%0d limit=%0d", cyc, HMAX);
        $fatal(1, "history overflow");
      end
      raw = {btn_down, btn_up, btn_left, btn_right};
      if (reset) begin
        for (int j = 0; j <= D + 2; j++) if (cyc - j >= 0) hist[cyc - j] = '0;
        mStable = '0; pending = '0; mTop = 0;
      end else begin
        outDir = prioOf(pending);
`ifdef REPEAT_EN
        if (outDir == 0 && mTop != 0) begin
          k = cyc - (topSince + 1);
          if (k == RD || (k > RD && ((k - RD) % RP) == 0)) outDir = mTop;
        end
`endif
        if (outDir != 0) expQ.push_back('{cyc, vecOf(outDir)});
        hist[cyc] = raw;
        press = '0;
        for (int b = 0; b < 4; b++) begin
          if (cyc - 1 - D >= 0) begin
            allOpp = 1'b1;
            for (int j = 2; j <= D + 1; j++)
              if (hist[cyc - j][b] == mStable[b]) allOpp = 1'b0;
            if (allOpp) begin
              mStable[b] = ~mStable[b];
              if (mStable[b]) press[b] = 1'b1;
            end
          end
        end
        pending = press;
`ifdef REPEAT_EN
        if (prioOf(mStable) != mTop) begin
          mTop     = prioOf(mStable);
          topSince = cyc;
        end
`endif
      end
    end
  end

  // Monitor: compares the DUT outputs every cycle against the scoreboard.
  initial begin
    logic [4:0] act, expv;
    exp_t e;
    nTests = 0;
    nFail  = 0;
    forever begin
      @(posedge clk);
      #2;
      act  = {move_en, move_right_en, move_left_en, move_up_en, move_down_en};
      expv = 5'b0;
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        e = expQ.pop_front();
        nTests++;
        nFail++;
        $display("FAIL missed_pulse cyc=%0d expected=%b at cyc %0d", cyc, e.vec, e.cyc);
      end
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        e    = expQ.pop_front();
        expv = e.vec;
      end
      nTests++;
      if (act !== expv) begin
        nFail++;
        $display("FAIL cmd_out cyc=%0d reset=%b actual=%b required=%b", cyc, reset, act, expv);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setBtn(input logic [3:0] v);
    {btn_down, btn_up, btn_left, btn_right} = v;
  endtask

  // Stimulus: directed scenarios then randomized button/reset activity.
  initial begin
    reset = 1'b1;
    setBtn(4'b0000);
    idle(3);
    reset = 1'b0;
    idle(5);

    // Clean right press held 50 cycles, then released.
    setBtn(4'b0001); idle(50);
    setBtn(4'b0000); idle(15);

    // Up bounces every 2 cycles for 20 cycles, then settles high.
    for (int i = 0; i < 10; i++) begin
      setBtn(4'b0100); idle(1);
      setBtn(4'b0000); idle(1);
    end
    setBtn(4'b0100); idle(20);
    setBtn(4'b0000); idle(15);

    // Left and down in the same cycle.
    setBtn(4'b1010); idle(30);
    setBtn(4'b0000); idle(15);

    // Down held across a 3-cycle reset.
    setBtn(4'b1000); idle(15);
    reset = 1'b1; idle(3);
    reset = 1'b0; idle(20);
    setBtn(4'b0000); idle(15);

    // Randomized button activity with occasional resets.
    for (int it = 0; it < 250; it++) begin
      setBtn(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        idle($urandom_range(1, 3));
        reset = 1'b0;
      end
      idle($urandom_range(1, 12));
    end

    setBtn(4'b0000);
    idle(30);
    nTests++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL drain actual=%0d pending required=0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
